// File: rtl/hdmi_cfg_pkg.sv
// Shared types, constants, the register table and the bus-level decode
// for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      START_C,
      SEND_BIT,
      ACK_BIT,
      STOP_C,
      GAP,
      FIN,
      FAIL
   } state_t;

   // Quarter-bit phase within a bit slot (or within a start/stop/gap slot).
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } phase_t;

   // Line levels driven toward the board pins.
   typedef struct packed {
      logic scl;
      logic sda_oe;
   } bus_t;

   // Slot and frame geometry.
   localparam phase_t     LAST_PHASE   = Q3;   // final quarter of every slot
   localparam phase_t     SAMPLE_PHASE = Q2;   // SCL high, SDA stable
   localparam logic [2:0] LAST_BIT     = 3'd7; // bytes go out MSB first
   localparam logic [1:0] LAST_BYTE    = 2'd2; // address, register, data

   // Default transmitter setup: {register, value}.
   localparam logic [15:0] CFG_TABLE [16] = '{
      16'h41_10,  // power up
      16'h98_03,  // fixed
      16'h9A_E0,  // fixed
      16'h9C_30,  // fixed
      16'h9D_61,  // fixed
      16'hA2_A4,  // fixed
      16'hA3_A4,  // fixed
      16'hE0_D0,  // fixed
      16'hF9_00,  // fixed
      16'h15_00,  // input id: 24-bit RGB 4:4:4
      16'h16_30,  // 8 bits per colour
      16'h17_02,  // 16:9 aspect
      16'h18_46,  // colour space converter off
      16'hAF_06,  // HDMI mode
      16'h40_80,  // general control packet enable
      16'hD6_C0   // HPD always high
   };

   // SCL / SDA levels for a given state, phase and outgoing data bit.
   function automatic bus_t drive_lines(input state_t st, input phase_t ph,
                                        input logic data_bit);
      bus_t b;
      b.scl    = 1'b1;
      b.sda_oe = 1'b0;
      case (st)
         START_C: begin
            // SDA falls while SCL is high, then SCL drops.
            b.scl    = (ph != Q3);
            b.sda_oe = (ph == Q2) || (ph == Q3);
         end
         SEND_BIT: begin
            b.scl    = (ph == Q1) || (ph == Q2);
            b.sda_oe = ~data_bit;
         end
         ACK_BIT: begin
            b.scl    = (ph == Q1) || (ph == Q2);
            b.sda_oe = 1'b0;
         end
         STOP_C: begin
            // SDA held low across the SCL rise, released while SCL is high.
            b.scl    = (ph != Q0);
            b.sda_oe = (ph == Q0) || (ph == Q1);
         end
         default: begin
            b.scl    = 1'b1;
            b.sda_oe = 1'b0;
         end
      endcase
      return b;
   endfunction

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Register table lookup: 6-bit entry index in, {register, value} out.
module hdmi_cfg_rom (
   input  logic [5:0]  addr,
   output logic [15:0] entry
);
   import hdmi_cfg_pkg::*;

   // Combinational table read; indices past the table return zero.
   always_comb begin
      case (addr)
         6'd0:    entry = CFG_TABLE[0];
         6'd1:    entry = CFG_TABLE[1];
         6'd2:    entry = CFG_TABLE[2];
         6'd3:    entry = CFG_TABLE[3];
         6'd4:    entry = CFG_TABLE[4];
         6'd5:    entry = CFG_TABLE[5];
         6'd6:    entry = CFG_TABLE[6];
         6'd7:    entry = CFG_TABLE[7];
         6'd8:    entry = CFG_TABLE[8];
         6'd9:    entry = CFG_TABLE[9];
         6'd10:   entry = CFG_TABLE[10];
         6'd11:   entry = CFG_TABLE[11];
         6'd12:   entry = CFG_TABLE[12];
         6'd13:   entry = CFG_TABLE[13];
         6'd14:   entry = CFG_TABLE[14];
         6'd15:   entry = CFG_TABLE[15];
         default: entry = 16'h0000;
      endcase
   end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// HDMI transmitter configuration sequencer: writes each table entry to the
// transmitter as an I2C frame, retries NACKed entries, reports DONE / ERR.
module hdmi_cfg_seq #(
   parameter logic [6:0] DEV_ADDR   = 7'h39,
   parameter int         NUM_REGS   = 16,
   parameter int         MAX_RETRY  = 3,
   parameter bit         AUTO_START = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TICK,
   input  logic       START,
   input  logic       SDA_IN,
   output logic       SCL_OUT,
   output logic       SDA_OE,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR,
   output logic [5:0] ERR_IDX
);
   import hdmi_cfg_pkg::*;

   localparam logic [5:0] LAST_IDX    = 6'(NUM_REGS - 1);
   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic [7:0]  shift_q, shift_d;
   logic [5:0]  idx_q, idx_d;
   logic [3:0]  retry_q, retry_d;
   logic        nack_q, nack_d;     // last ACK slot saw a NACK
   logic        pend_q, pend_d;     // start request waiting for a tick
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [5:0]  err_idx_q, err_idx_d;
   logic        scl_q, scl_d;
   logic        sda_oe_q, sda_oe_d;
   logic [15:0] entry;
   bus_t        lines;

   hdmi_cfg_rom u_rom (
      .addr  (idx_q),
      .entry (entry)
   );

   // Next-state, counter and line-level decode; advances only on TICK.
   // NOTE: every signal gets its hold value first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      nack_d    = nack_q;
      pend_d    = pend_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;

      // START is only honoured while no sequence is running.
      if (START && !busy_q) begin
         pend_d = 1'b1;
      end

      if (TICK) begin
         phase_d = phase_t'(phase_q + 2'd1);
         case (state_q)
            IDLE: begin
               phase_d = Q0;
               if (pend_q || START) begin
                  state_d = START_C;
                  pend_d  = 1'b0;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  idx_d   = 6'd0;
                  retry_d = 4'd0;
                  nack_d  = 1'b0;
               end
            end

            START_C: begin
               if (phase_q == LAST_PHASE) begin
                  state_d = SEND_BIT;
                  bit_d   = 3'd0;
                  byte_d  = 2'd0;
                  shift_d = {DEV_ADDR, 1'b0};
               end
            end

            SEND_BIT: begin
               if (phase_q == LAST_PHASE) begin
                  if (bit_q == LAST_BIT) begin
                     state_d = ACK_BIT;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end
            end

            ACK_BIT: begin
               if (phase_q == SAMPLE_PHASE) begin
                  nack_d = SDA_IN;
               end
               if (phase_q == LAST_PHASE) begin
                  if (nack_q || (byte_q == LAST_BYTE)) begin
                     state_d = STOP_C;
                  end else begin
                     state_d = SEND_BIT;
                     bit_d   = 3'd0;
                     byte_d  = byte_q + 2'd1;
                     shift_d = (byte_q == 2'd0) ? entry[15:8] : entry[7:0];
                  end
               end
            end

            STOP_C: begin
               if (phase_q == LAST_PHASE) begin
                  if (nack_q && (retry_q == RETRY_LIMIT)) begin
                     state_d   = FAIL;
                     busy_d    = 1'b0;
                     err_d     = 1'b1;
                     err_idx_d = idx_q;
                  end else begin
                     state_d = GAP;
                  end
               end
            end

            GAP: begin
               if (phase_q == LAST_PHASE) begin
                  if (nack_q) begin
                     // Same entry again.
                     state_d = START_C;
                     retry_d = retry_q + 4'd1;
                  end else if (idx_q == LAST_IDX) begin
                     state_d = FIN;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = START_C;
                     idx_d   = idx_q + 6'd1;
                     retry_d = 4'd0;
                  end
               end
            end

            FIN, FAIL: begin
               phase_d = Q0;
               state_d = IDLE;
            end

            default: begin
               phase_d = Q0;
               state_d = IDLE;
            end
         endcase
      end

      lines    = drive_lines(state_d, phase_d, shift_d[7]);
      scl_d    = lines.scl;
      sda_oe_d = lines.sda_oe;
   end

   // State and registered outputs; reset releases the bus immediately.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         phase_q   <= Q0;
         bit_q     <= 3'd0;
         byte_q    <= 2'd0;
         shift_q   <= 8'h00;
         idx_q     <= 6'd0;
         retry_q   <= 4'd0;
         nack_q    <= 1'b0;
         pend_q    <= AUTO_START;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= 6'd0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         nack_q    <= nack_d;
         pend_q    <= pend_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
      end
   end

   assign SCL_OUT = scl_q;
   assign SDA_OE  = sda_oe_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign ERR     = err_q;
   assign ERR_IDX = err_idx_q;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Bench for hdmi_cfg_seq: an I2C slave model decodes frames off the bus,
// ACKs or NACKs on demand, and the decoded frames are compared to a table.
module tb_hdmi_cfg_seq;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       TICK = 1'b0;
   logic       START = 1'b0;
   logic       SDA_IN;
   logic       SCL_OUT, SDA_OE, BUSY, DONE, ERR;
   logic [5:0] ERR_IDX;

   // Open-drain SDA: low if the DUT or the slave pulls.
   logic pull = 1'b0;
   logic sda_line;
   assign sda_line = !(SDA_OE || pull);
   assign SDA_IN   = sda_line;

   hdmi_cfg_seq dut (
      .CLK     (CLK),
      .RST     (RST),
      .TICK    (TICK),
      .START   (START),
      .SDA_IN  (SDA_IN),
      .SCL_OUT (SCL_OUT),
      .SDA_OE  (SDA_OE),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .ERR     (ERR),
      .ERR_IDX (ERR_IDX)
   );

   always #5 CLK = ~CLK;

   // Quarter-bit strobe every 5 clocks; counts ticks consumed while busy.
   int seq_ticks = 0;
   initial begin
      forever begin
         @(negedge CLK);
         if (BUSY) seq_ticks++;
         TICK = 1'b1;
         @(negedge CLK);
         TICK = 1'b0;
         repeat (3) @(negedge CLK);
      end
   end

   // ---------------- I2C slave / bus monitor ----------------
   logic [7:0] nack_reg   = 8'h00;  // register byte to refuse
   int         nack_allow = 0;      // NACKs permitted up to this running total
   int         nack_total = 0;

   logic       prev_scl = 1'b1, prev_sda = 1'b1, m_scl, m_sda;
   bit         in_frame = 1'b0, acked = 1'b0;
   int         bit_n = 0, byte_n = 0;
   logic [7:0] shreg = 8'h00;
   logic [7:0] cur [3];
   int         frame_cnt = 0, violations = 0;
   logic [7:0] f_b0 [256];
   logic [7:0] f_b1 [256];
   logic [7:0] f_b2 [256];
   int         f_nb [256];

   always @(negedge CLK) begin
      if (RST) begin
         in_frame = 1'b0;
         bit_n    = 0;
         byte_n   = 0;
         pull     = 1'b0;
         prev_scl = 1'b1;
         prev_sda = 1'b1;
      end else begin
         m_scl = SCL_OUT;
         m_sda = sda_line;
         if (prev_scl && m_scl && prev_sda && !m_sda) begin
            if (in_frame) violations++;
            in_frame = 1'b1;
            bit_n    = 0;
            byte_n   = 0;
            for (int i = 0; i < 3; i++) cur[i] = 8'h00;
         end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
            // The stop's own SCL rise counts as one clock into the next byte.
            if (!in_frame || bit_n != 1) begin
               violations++;
            end else if (frame_cnt < 256) begin
               f_b0[frame_cnt] = cur[0];
               f_b1[frame_cnt] = cur[1];
               f_b2[frame_cnt] = cur[2];
               f_nb[frame_cnt] = byte_n;
               frame_cnt++;
            end
            in_frame = 1'b0;
         end else if (!prev_scl && m_scl && in_frame) begin
            if (bit_n < 8) shreg = {shreg[6:0], m_sda};
            bit_n++;
         end else if (prev_scl && !m_scl && in_frame) begin
            if (bit_n == 8) begin
               if (byte_n < 3) cur[byte_n] = shreg;
               if (byte_n == 0) begin
                  acked = (shreg == 8'h72);
               end else if (byte_n == 1 && shreg == nack_reg && nack_total < nack_allow) begin
                  acked = 1'b0;
                  nack_total++;
               end else begin
                  acked = 1'b1;
               end
               pull = acked;
            end else if (bit_n == 9) begin
               pull  = 1'b0;
               bit_n = 0;
               if (acked) byte_n++;
            end
         end
         prev_scl = m_scl;
         prev_sda = m_sda;
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_busy(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (BUSY) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (DONE || ERR) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic int count_reg(input int from, input int to, input logic [7:0] r,
                                    input bit full_only);
      int n = 0;
      for (int i = from; i < to; i++) begin
         if (f_b1[i] == r && (!full_only || f_nb[i] == 3)) n++;
      end
      return n;
   endfunction

   typedef struct {
      logic [7:0] rg;
      logic [7:0] val;
   } vec_t;

   vec_t vec [16];

   initial begin
      #(800_000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_f, base_t;
      bit ok;

      vec[0]  = '{8'h41, 8'h10};  vec[1]  = '{8'h98, 8'h03};
      vec[2]  = '{8'h9A, 8'hE0};  vec[3]  = '{8'h9C, 8'h30};
      vec[4]  = '{8'h9D, 8'h61};  vec[5]  = '{8'hA2, 8'hA4};
      vec[6]  = '{8'hA3, 8'hA4};  vec[7]  = '{8'hE0, 8'hD0};
      vec[8]  = '{8'hF9, 8'h00};  vec[9]  = '{8'h15, 8'h00};
      vec[10] = '{8'h16, 8'h30};  vec[11] = '{8'h17, 8'h02};
      vec[12] = '{8'h18, 8'h46};  vec[13] = '{8'hAF, 8'h06};
      vec[14] = '{8'h40, 8'h80};  vec[15] = '{8'hD6, 8'hC0};

      // Reset state.
      repeat (3) @(negedge CLK);
      check("rst_scl", SCL_OUT, 1);
      check("rst_sda_oe", SDA_OE, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_err", ERR, 0);
      check("rst_err_idx", ERR_IDX, 0);

      // Auto-start after reset release, slave always ACKs; START while busy.
      base_f = frame_cnt;
      base_t = seq_ticks;
      RST = 1'b0;
      wait_busy(100, ok);
      check("auto_start_busy", ok, 1);
      repeat (2000) @(negedge CLK);
      check("busy_mid_seq", BUSY, 1);
      pulse_start();
      wait_end(12000, ok);
      check("seq1_ended", ok, 1);
      check("seq1_ticks", seq_ticks - base_t, 1920);
      check("seq1_frames", frame_cnt - base_f, 16);
      check("seq1_done", DONE, 1);
      check("seq1_err", ERR, 0);
      check("seq1_busy", BUSY, 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("seq1_addr[%0d]", i), f_b0[base_f + i], 8'h72);
         check($sformatf("seq1_reg[%0d]", i), f_b1[base_f + i], vec[i].rg);
         check($sformatf("seq1_val[%0d]", i), f_b2[base_f + i], vec[i].val);
         check($sformatf("seq1_nbytes[%0d]", i), f_nb[base_f + i], 3);
      end
      repeat (200) @(negedge CLK);
      check("busy_start_ignored_frames", frame_cnt - base_f, 16);
      check("busy_start_ignored_idle", BUSY, 0);
      check("seq1_done_held", DONE, 1);

      // START after DONE; entry 5 NACKed twice then ACKed.
      nack_reg   = 8'hA2;
      nack_allow = nack_total + 2;
      base_f = frame_cnt;
      pulse_start();
      wait_busy(100, ok);
      check("seq2_started", ok, 1);
      check("seq2_done_cleared", DONE, 0);
      wait_end(14000, ok);
      check("seq2_ended", ok, 1);
      check("seq2_done", DONE, 1);
      check("seq2_err", ERR, 0);
      check("seq2_frames", frame_cnt - base_f, 18);
      check("seq2_entry5_attempts", count_reg(base_f, frame_cnt, 8'hA2, 1'b0), 3);
      check("seq2_entry5_full", count_reg(base_f, frame_cnt, 8'hA2, 1'b1), 1);
      check("seq2_last_reg", f_b1[frame_cnt - 1], 8'hD6);
      check("seq2_last_val", f_b2[frame_cnt - 1], 8'hC0);

      // Entry 2 NACKed permanently: 1 + MAX_RETRY attempts, then abort.
      nack_reg   = 8'h9A;
      nack_allow = nack_total + 1000;
      base_f = frame_cnt;
      pulse_start();
      wait_busy(100, ok);
      check("seq3_started", ok, 1);
      wait_end(14000, ok);
      check("seq3_ended", ok, 1);
      check("seq3_err", ERR, 1);
      check("seq3_done", DONE, 0);
      check("seq3_err_idx", ERR_IDX, 2);
      check("seq3_busy", BUSY, 0);
      repeat (400) @(negedge CLK);
      check("seq3_frames", frame_cnt - base_f, 6);
      check("seq3_entry2_attempts", count_reg(base_f, frame_cnt, 8'h9A, 1'b0), 4);
      check("seq3_last_nbytes", f_nb[frame_cnt - 1], 1);
      check("seq3_err_held", ERR, 1);
      nack_allow = nack_total;

      // Reset during the data byte of entry 7, then auto-restart from entry 0.
      pulse_start();
      wait_busy(100, ok);
      check("seq4_started", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge CLK);
         if (in_frame && byte_n == 2 && bit_n == 3 && cur[1] == 8'hE0) begin
            ok = 1'b1;
            break;
         end
      end
      check("seq4_reached_entry7_data", ok, 1);
      #2 RST = 1'b1;
      #1;
      check("midrst_scl", SCL_OUT, 1);
      check("midrst_sda_oe", SDA_OE, 0);
      check("midrst_busy", BUSY, 0);
      repeat (4) @(negedge CLK);
      base_f = frame_cnt;
      RST = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (frame_cnt > base_f) begin
            ok = 1'b1;
            break;
         end
      end
      check("restart_frame_seen", ok, 1);
      check("restart_addr", f_b0[base_f], 8'h72);
      check("restart_reg", f_b1[base_f], 8'h41);
      check("restart_val", f_b2[base_f], 8'h10);
      check("restart_busy", BUSY, 1);

      check("bus_protocol_violations", violations, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hdmi_cfg_seq.md
# hdmi_cfg_seq

Configuration sequencer for the HDMI transmitter. Out of reset, or on request, it walks a fixed table of (register, value) pairs and writes each pair over I2C to the transmitter's register file. It is clocked by the 50 MHz system clock and paced by a quarter-bit strobe derived from the I2C clock-divider output. It sits between the clock source and the board I2C pins, and reports completion to the video pipeline before the pixel path is enabled.

## Interface
- DEV_ADDR, 7'h39: 7-bit I2C device address of the transmitter.
- NUM_REGS, 16: number of table entries written per sequence (1..64).
- MAX_RETRY, 3: NACK retries per entry before aborting.
- AUTO_START, 1: 1 = start a sequence automatically after reset release.

- CLK  in  1  system clock (50 MHz).
- RST  in  1  reset, asynchronous assert, active-high.
- TICK  in  1  one-CLK-wide strobe at 4x SCL rate (quarter-bit period).
- START  in  1  pulse; begins a sequence when idle; ignored while BUSY.
- SDA_IN  in  1  sampled SDA line (already synchronised).
- SCL_OUT  out  1  SCL level (1 = released/high).
- SDA_OE  out  1  1 = pull SDA low; 0 = release.
- BUSY  out  1  sequence in progress.
- DONE  out  1  level; all NUM_REGS entries acknowledged.
- ERR  out  1  level; sequence aborted after retry exhaustion.
- ERR_IDX  out  6  table index of the failing entry.

## Operation
- Reset values: SCL_OUT=1, SDA_OE=0, BUSY=0, DONE=0, ERR=0, ERR_IDX=0, entry index=0, retry count=0.
- FSM states: IDLE, START_C, SEND_BIT, ACK_BIT, STOP_C, GAP, FIN, FAIL.
- IDLE -> START_C when (START or pending auto-start) on a TICK. Entering START_C sets BUSY=1 and clears DONE/ERR.
- Each entry is one frame: start, byte {DEV_ADDR,0}, ACK, register byte, ACK, data byte, ACK, stop. Bytes are sent MSB first.
- SDA_OE = ~bit while sending. SDA_OE = 0 during ACK slots.
- ACK slot: SDA_IN==0 is ACK. SDA_IN==1 is NACK: abort the frame, go to STOP_C, retry the same entry. Retry count increments.
- The retry count resets on each ACKed entry. A NACK when retry==MAX_RETRY leads to STOP_C, then FAIL.
- After stop: GAP (one bit slot, lines released), then the next entry. After entry NUM_REGS-1 is ACKed, go to FIN.
- FIN: DONE=1, BUSY=0, return to IDLE.
- FAIL: ERR=1, ERR_IDX=index, BUSY=0, return to IDLE.
- START while BUSY is ignored. START in IDLE restarts from index 0.
- Table entries are {reg[7:0], val[7:0]} from sub-module hdmi_cfg_rom, indexed by 6-bit address. Combinational read.

## Timing
- All state advances only on CLK edges where TICK=1. Between ticks, outputs hold.
- Bit slot = 4 phases. q0: SCL=0, SDA updated. q1: SCL=1. q2: SCL=1, SDA_IN sampled (ACK slots). q3: SCL=0.
- START_C: SDA released with SCL=1 for 2 phases, then SDA_OE=1 with SCL=1 for 1 phase, then SCL=0 for 1 phase.
- STOP_C: SCL=0/SDA_OE=1 for 1 phase, SCL=1 for 1 phase, then SDA released for 2 phases.
- Frame length: 4 (start) + 27x4 (bits) + 4 (stop) = 116 ticks. Plus 4 ticks of GAP.
- Sequence of NUM_REGS entries, no NACK: NUM_REGS x 120 ticks from first TICK after start.
- DONE/ERR assert on the CLK edge of the final tick and stay until the next sequence starts.
- RST mid-frame: immediate return to reset values. The bus is released (SCL=1, SDA_OE=0). If AUTO_START=1, the sequence restarts from index 0 after release.

## Structure
- Package hdmi_cfg_pkg holds:
  - the state enum;
  - phase encoding;
  - frame/slot length constants;
  - the default register table.
- Sub-module hdmi_cfg_rom: a case-based table taking a 6-bit index and returning a 16-bit entry.
- Top holds the FSM, bit/phase counters, shift register, and retry/index counters.

## Test plan
- Reset, then TICK every 5 CLK, slave always ACKs -> exactly 16 frames; byte 1 of every frame = 0x72; DONE=1 after 1920 ticks; BUSY=0.
- Entry 0 = {0x41,0x10} -> bytes on the bus 0x72, 0x41, 0x10. SDA changes only while SCL=0, except at start/stop.
- Slave NACKs entry 5 twice, then ACKs -> entry 5 is sent 3 times; the sequence completes with DONE=1 and ERR=0.
- Slave NACKs entry 2 permanently -> 4 attempts (1 + MAX_RETRY), then stop; ERR=1, ERR_IDX=2, DONE=0.
- RST asserted during the data byte of entry 7 -> same cycle: SCL_OUT=1, SDA_OE=0, BUSY=0. After release, the next frame carries register byte of entry 0.
- START pulsed while BUSY -> ignored, no extra frames. START pulsed after DONE -> DONE clears and 16 new frames follow.
